// File: rtl/led_cnt_pkg.sv
// Shared types and constants for the LED blink decoder: counter/divider widths,
// FSM encoding, output status bundle and the expected half-period helper.
package led_cnt_pkg;

    localparam int unsigned CNT_W = 28;
    localparam int unsigned DIV_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [DIV_W-1:0] div_t;

    localparam cnt_t        CNT_1S  = 28'h5F5E100;
    localparam int unsigned DIV_MAX = 20;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        SEARCH
    } state_t;

    typedef struct packed {
        cnt_t half_period;
        div_t div;
        logic div_valid;
        logic locked;
        logic err;
        logic stall;
        logic overrun;
    } status_t;

    // Half-period produced by the blinker at divider d; only ever called with constant d.
    function automatic cnt_t exp_half(div_t d, cnt_t base = CNT_1S);
        return base / cnt_t'(d) + cnt_t'(1);
    endfunction

endpackage

// File: rtl/led_blink_decoder_if.sv
// Monitored LED line plus decoder status outputs; the decoder is the slave side.
interface led_blink_decoder_if;
    import led_cnt_pkg::*;

    logic led_i;
    cnt_t half_period_o;
    div_t div_o;
    logic div_valid_o;
    logic locked_o;
    logic err_o;
    logic stall_o;
    logic overrun_o;

    modport master (
        output led_i,
        input  half_period_o, div_o, div_valid_o, locked_o, err_o, stall_o, overrun_o
    );

    modport slave (
        input  led_i,
        output half_period_o, div_o, div_valid_o, locked_o, err_o, stall_o, overrun_o
    );

endinterface

// File: rtl/led_edge_sync.sv
// Synchronizer chain for the asynchronous LED line plus any-edge detection.
module led_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_c = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/led_blink_decoder.sv
// Measures the LED toggle-to-toggle interval and searches dividers 1..DIV_MAX
// (lowest first, one per cycle) for the blinker setting that produced it.
module led_blink_decoder #(
    parameter logic [27:0] CNT_1S      = led_cnt_pkg::CNT_1S,
    parameter int unsigned DIV_MAX     = led_cnt_pkg::DIV_MAX,
    parameter int unsigned TOL         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [27:0] TIMEOUT     = 28'hBEBC200
) (
    input  logic               clk100,
    input  logic               rst,
    led_blink_decoder_if.slave bus
);
    import led_cnt_pkg::*;

    localparam cnt_t TOL_C = cnt_t'(TOL);

    logic    edge_c;
    logic    timeout_c;
    logic    match_c;
    cnt_t    exp_c;
    cnt_t    diff_c;
    cnt_t    cnt_q;
    state_t  state_q, state_n;
    div_t    d_q, d_n;
    status_t st_q, st_n;

    led_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk100),
        .rst   (rst),
        .din   (bus.led_i),
        .edge_c(edge_c)
    );

    // Interval counter: restarts at 1 on every edge, parks at TIMEOUT.
    always_ff @(posedge clk100) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (edge_c) begin
            cnt_q <= cnt_t'(1);
        end else if (cnt_q != TIMEOUT) begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

    assign timeout_c = (cnt_q == TIMEOUT);

    // Expected values fold to constants per divider; the loop becomes a small mux.
    always_comb begin
        exp_c = '0;
        for (int unsigned i = 1; i <= DIV_MAX; i++) begin
            if (d_q == div_t'(i)) begin
                exp_c = exp_half(div_t'(i), CNT_1S);
            end
        end
        diff_c  = (st_q.half_period >= exp_c) ? (st_q.half_period - exp_c)
                                              : (exp_c - st_q.half_period);
        match_c = (diff_c <= TOL_C);
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q <= WAIT_FIRST;
            d_q     <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_n;
            d_q     <= d_n;
            st_q    <= st_n;
        end
    end

    // Edge beats timeout, timeout beats the compare result.
    always_comb begin
        state_n    = state_q;
        d_n        = d_q;
        st_n       = st_q;
        st_n.err     = 1'b0;
        st_n.overrun = 1'b0;

        unique case (state_q)
            WAIT_FIRST: begin
                if (edge_c) begin
                    st_n.stall = 1'b0;
                    state_n    = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    st_n.half_period = cnt_q;
                    d_n              = div_t'(1);
                    state_n          = SEARCH;
                end else if (timeout_c) begin
                    st_n.stall     = 1'b1;
                    st_n.div_valid = 1'b0;
                    st_n.locked    = 1'b0;
                    state_n        = WAIT_FIRST;
                end
            end
            SEARCH: begin
                if (edge_c) begin
                    st_n.half_period = cnt_q;
                    st_n.overrun     = 1'b1;
                    d_n              = div_t'(1);
                end else if (timeout_c) begin
                    st_n.stall     = 1'b1;
                    st_n.div_valid = 1'b0;
                    st_n.locked    = 1'b0;
                    state_n        = WAIT_FIRST;
                end else if (match_c) begin
                    st_n.div       = d_q;
                    st_n.div_valid = 1'b1;
                    st_n.locked    = st_q.div_valid && (st_q.div == d_q);
                    state_n        = MEASURE;
                end else if (d_q == div_t'(DIV_MAX)) begin
                    st_n.err       = 1'b1;
                    st_n.div_valid = 1'b0;
                    st_n.locked    = 1'b0;
                    state_n        = MEASURE;
                end else begin
                    d_n = d_q + div_t'(1);
                end
            end
            default: state_n = WAIT_FIRST;
        endcase
    end

    assign bus.half_period_o = st_q.half_period;
    assign bus.div_o         = st_q.div;
    assign bus.div_valid_o   = st_q.div_valid;
    assign bus.locked_o      = st_q.locked;
    assign bus.err_o         = st_q.err;
    assign bus.stall_o       = st_q.stall;
    assign bus.overrun_o     = st_q.overrun;

endmodule
